// File: rtl/wu_mem_arb.sv
// wu_mem_arb: arbitrates the WU instruction memory between fetch reads
// (buffered in an in-order skid FIFO) and system load writes. Writes win
// for up to WR_BURST consecutive grants while a read waits, then one read
// is forced through. Memory strobes are registered one cycle after grant;
// read data returns RD_LAT cycles after the read strobe, in issue order.
module wu_mem_arb #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SKID_DEPTH = 8,
    parameter int unsigned WR_BURST   = 4,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              reset_poweron_n,
    input  logic              wuf__wuma__read,
    input  logic [ADDR_W-1:0] wuf__wuma__addr,
    output logic              wuma__wuf__stall,
    input  logic              sys__wuma__wr_valid,
    input  logic [ADDR_W-1:0] sys__wuma__wr_addr,
    input  logic [DATA_W-1:0] sys__wuma__wr_data,
    output logic              wuma__sys__wr_ready,
    input  logic              wud__wuma__stall,
    output logic              wuma__wum__read,
    output logic              wuma__wum__write,
    output logic [ADDR_W-1:0] wuma__wum__addr,
    output logic [DATA_W-1:0] wuma__wum__wdata,
    input  logic [DATA_W-1:0] wum__wuma__rdata,
    output logic              wuma__wud__rdata_valid,
    output logic [DATA_W-1:0] wuma__wud__rdata,
    output logic              wuma__err
);

    localparam int unsigned PTR_W    = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(SKID_DEPTH + 1);
    localparam int unsigned WRC_W    = $clog2(WR_BURST + 1);
    // Two reads may still arrive after stall is seen, plus one in the
    // stall register itself, hence the three-entry margin.
    localparam int unsigned STALL_TH = (SKID_DEPTH > 3) ? (SKID_DEPTH - 3) : 0;

    // Skid FIFO storage and bookkeeping
    logic [ADDR_W-1:0] fifo_mem_q [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Arbitration state and flags
    logic [WRC_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              err_q, err_d;
    logic              stall_q, stall_d;

    // Registered memory interface
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Read-return valid pipeline
    logic [RD_LAT-1:0] vpipe_q, vpipe_d;

    // Combinational decision signals
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_ok;
    logic              push_drop;
    logic              rd_elig;
    logic              wr_elig;
    logic              grant_wr;
    logic              grant_rd;
    logic [ADDR_W-1:0] fifo_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Eligibility and single-grant arbitration for this cycle
    always_comb begin
        fifo_full  = (count_q == CNT_W'(SKID_DEPTH));
        fifo_empty = (count_q == '0);
        fifo_head  = fifo_mem_q[rd_ptr_q];
        push_ok    = wuf__wuma__read && !fifo_full;
        push_drop  = wuf__wuma__read && fifo_full;
        rd_elig    = !fifo_empty && !wud__wuma__stall;
        wr_elig    = sys__wuma__wr_valid;
        grant_wr   = wr_elig && (!rd_elig || (wr_cnt_q < WRC_W'(WR_BURST)));
        grant_rd   = rd_elig && !grant_wr;
    end

    // FIFO pointers, occupancy, sticky overflow and registered stall
    always_comb begin
        wr_ptr_d = push_ok  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = grant_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !grant_rd) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && grant_rd) begin
            count_d = count_q - 1'b1;
        end
        err_d   = err_q || push_drop;
        stall_d = (count_d >= CNT_W'(STALL_TH)) || wud__wuma__stall || grant_wr;
    end

    // Write-burst counter: only counts writes that actually starve a read
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (grant_rd || !rd_elig) begin
            wr_cnt_d = '0;
        end else if (grant_wr && (wr_cnt_q != WRC_W'(WR_BURST))) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    // Next memory command; address and data hold when idle
    always_comb begin
        mem_rd_d    = grant_rd;
        mem_wr_d    = grant_wr;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (grant_rd) begin
            mem_addr_d = fifo_head;
        end else if (grant_wr) begin
            mem_addr_d  = sys__wuma__wr_addr;
            mem_wdata_d = sys__wuma__wr_data;
        end
    end

    // Valid pipeline fed by the issued read strobe
    always_comb begin
        vpipe_d    = vpipe_q;
        vpipe_d[0] = mem_rd_q;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
    end

    // FIFO storage needs no reset: entries are only read behind the pointers
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= wuf__wuma__addr;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_cnt_q    <= '0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vpipe_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_cnt_q    <= wr_cnt_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            vpipe_q     <= vpipe_d;
        end
    end

    // Output drive; read data is gated so it reads 0 when not valid
    always_comb begin
        wuma__sys__wr_ready    = grant_wr;
        wuma__wuf__stall       = stall_q;
        wuma__err              = err_q;
        wuma__wum__read        = mem_rd_q;
        wuma__wum__write       = mem_wr_q;
        wuma__wum__addr        = mem_addr_q;
        wuma__wum__wdata       = mem_wdata_q;
        wuma__wud__rdata_valid = vpipe_q[RD_LAT-1];
        wuma__wud__rdata       = vpipe_q[RD_LAT-1] ? wum__wuma__rdata : '0;
    end

endmodule

// File: tb/tb_wu_mem_arb.sv
// Testbench for wu_mem_arb: directed vector table, hand-written corner
// sequences and randomized traffic, all checked every cycle against a
// queue-based behavioural model of the arbiter.
module tb_wu_mem_arb;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int WB    = 4;
    localparam int LAT   = 2;

    logic          clk;
    logic          rst_n;
    logic          f_rd;
    logic [AW-1:0] f_addr;
    logic          o_stall;
    logic          w_valid;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          o_ready;
    logic          d_stall;
    logic          o_mrd;
    logic          o_mwr;
    logic [AW-1:0] o_maddr;
    logic [DW-1:0] o_mwdata;
    logic [DW-1:0] mem_rdata;
    logic          o_valid;
    logic [DW-1:0] o_rdata;
    logic          o_err;

    wu_mem_arb #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .SKID_DEPTH(DEPTH),
        .WR_BURST  (WB),
        .RD_LAT    (LAT)
    ) dut (
        .clk                   (clk),
        .reset_poweron_n       (rst_n),
        .wuf__wuma__read       (f_rd),
        .wuf__wuma__addr       (f_addr),
        .wuma__wuf__stall      (o_stall),
        .sys__wuma__wr_valid   (w_valid),
        .sys__wuma__wr_addr    (w_addr),
        .sys__wuma__wr_data    (w_data),
        .wuma__sys__wr_ready   (o_ready),
        .wud__wuma__stall      (d_stall),
        .wuma__wum__read       (o_mrd),
        .wuma__wum__write      (o_mwr),
        .wuma__wum__addr       (o_maddr),
        .wuma__wum__wdata      (o_mwdata),
        .wum__wuma__rdata      (mem_rdata),
        .wuma__wud__rdata_valid(o_valid),
        .wuma__wud__rdata      (o_rdata),
        .wuma__err             (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents as a fixed function of address
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return {a ^ 16'hC3A5, a};
    endfunction

    // Memory responder: answers each read strobe LAT cycles later
    logic [DW:0] rsp_q [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) rsp_q[i] <= '0;
        end else begin
            rsp_q[0] <= {o_mrd, mem_f(o_maddr)};
            for (int i = 1; i < LAT; i++) rsp_q[i] <= rsp_q[i-1];
        end
    end
    assign mem_rdata = rsp_q[LAT-1][DW] ? rsp_q[LAT-1][DW-1:0] : 32'hDEAD_BEEF;

    // Behavioural reference model
    typedef struct {
        int unsigned   due;
        logic [AW-1:0] addr;
    } pend_t;

    logic [AW-1:0] md_fifo [$];
    pend_t         md_pend [$];
    int unsigned   md_wrcnt;
    bit            md_err;
    bit            md_stall;
    bit            md_mrd;
    bit            md_mwr;
    logic [AW-1:0] md_maddr;
    logic [DW-1:0] md_wdata;
    int unsigned   cyc;
    int            n_chk;
    int            n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        md_fifo.delete();
        md_pend.delete();
        md_wrcnt = 0;
        md_err   = 1'b0;
        md_stall = 1'b0;
        md_mrd   = 1'b0;
        md_mwr   = 1'b0;
        md_maddr = '0;
        md_wdata = '0;
    endtask

    // One clock cycle: drive inputs, check DUT against model, advance model
    task automatic tick(input bit i_rd, input logic [AW-1:0] i_ra, input bit i_wv,
                        input logic [AW-1:0] i_wa, input logic [DW-1:0] i_wd, input bit i_ds);
        bit rd_el, gw, gr, full, exp_v;
        @(negedge clk);
        cyc++;
        f_rd    = i_rd;
        f_addr  = i_ra;
        w_valid = i_wv;
        w_addr  = i_wa;
        w_data  = i_wd;
        d_stall = i_ds;
        #1;
        rd_el = (md_fifo.size() != 0) && !i_ds;
        gw    = i_wv && (!rd_el || (md_wrcnt < WB));
        gr    = rd_el && !gw;
        exp_v = (md_pend.size() != 0) && (md_pend[0].due == cyc);
        chk("wr_ready",    64'(o_ready),  64'(gw));
        chk("fetch_stall", 64'(o_stall),  64'(md_stall));
        chk("mem_read",    64'(o_mrd),    64'(md_mrd));
        chk("mem_write",   64'(o_mwr),    64'(md_mwr));
        chk("mem_addr",    64'(o_maddr),  64'(md_maddr));
        chk("mem_wdata",   64'(o_mwdata), 64'(md_wdata));
        chk("err",         64'(o_err),    64'(md_err));
        chk("rdata_valid", 64'(o_valid),  64'(exp_v));
        if (exp_v) begin
            chk("rdata", 64'(o_rdata), 64'(mem_f(md_pend[0].addr)));
            void'(md_pend.pop_front());
        end
        full = (md_fifo.size() >= DEPTH);
        if (gr) begin
            md_pend.push_back('{due: cyc + 1 + LAT, addr: md_fifo[0]});
            md_maddr = md_fifo[0];
            void'(md_fifo.pop_front());
        end
        if (i_rd) begin
            if (full) md_err = 1'b1;
            else      md_fifo.push_back(i_ra);
        end
        if (gw) begin
            md_maddr = i_wa;
            md_wdata = i_wd;
        end
        md_mrd = gr;
        md_mwr = gw;
        if (gr || !rd_el)                md_wrcnt = 0;
        else if (gw && (md_wrcnt < WB))  md_wrcnt = md_wrcnt + 1;
        md_stall = (md_fifo.size() >= DEPTH - 3) || i_ds || gw;
    endtask

    task automatic idle(input bit i_ds);
        tick(1'b0, '0, 1'b0, '0, '0, i_ds);
    endtask

    // Asynchronous reset mid-cycle, with an immediate all-zero output check
    task automatic apply_reset();
        f_rd = 1'b0; f_addr = '0; w_valid = 1'b0; w_addr = '0; w_data = '0; d_stall = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_stall", 64'(o_stall),  64'd0);
        chk("rst_ready", 64'(o_ready),  64'd0);
        chk("rst_mrd",   64'(o_mrd),    64'd0);
        chk("rst_mwr",   64'(o_mwr),    64'd0);
        chk("rst_maddr", 64'(o_maddr),  64'd0);
        chk("rst_wdata", 64'(o_mwdata), 64'd0);
        chk("rst_valid", 64'(o_valid),  64'd0);
        chk("rst_rdata", 64'(o_rdata),  64'd0);
        chk("rst_err",   64'(o_err),    64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit            rd;
        logic [AW-1:0] ra;
        bit            wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            ds;
        bit            e_ready;
        bit            e_mrd;
        bit            e_mwr;
        logic [AW-1:0] e_maddr;
        logic [DW-1:0] e_wdata;
        bit            e_stall;
        bit            e_valid;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit s1, s2, rdv;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        rst_n  = 1'b1;
        model_reset();

        // Single fetch read at 0x10, then a lone write
        vecs[0] = '{1'b1, 16'h0010, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0,        1'b0, 1'b1, mem_f(16'h0010)};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 16'h0022, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 16'h0022, 32'h12345678, 1'b1, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0022, 32'h12345678, 1'b0, 1'b0, 32'h0};

        apply_reset();
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].rd, vecs[i].ra, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].ds);
            chk("tbl_ready", 64'(o_ready),  64'(vecs[i].e_ready));
            chk("tbl_mrd",   64'(o_mrd),    64'(vecs[i].e_mrd));
            chk("tbl_mwr",   64'(o_mwr),    64'(vecs[i].e_mwr));
            chk("tbl_maddr", 64'(o_maddr),  64'(vecs[i].e_maddr));
            chk("tbl_wdata", 64'(o_mwdata), 64'(vecs[i].e_wdata));
            chk("tbl_stall", 64'(o_stall),  64'(vecs[i].e_stall));
            chk("tbl_valid", 64'(o_valid),  64'(vecs[i].e_valid));
            if (vecs[i].e_valid) chk("tbl_rdata", 64'(o_rdata), 64'(vecs[i].e_rdata));
        end

        // Continuous writes against waiting reads: 4 writes then 1 read
        apply_reset();
        for (int t = 0; t < 20; t++) begin
            rdv = (t < 5) || (t % 5 == 0);
            tick(rdv, 16'(16'h0100 + t), 1'b1, 16'(16'h0200 + t), 32'(32'hA000_0000 + t), 1'b0);
            chk("burst_ready", 64'(o_ready), 64'((t == 0) || (t % 5 != 0)));
            if (t >= 1) chk("burst_stall", 64'(o_stall), 64'd1);
        end
        repeat (12) idle(1'b0);

        // Decoder stall while fetch streams with a two-cycle reaction lag
        apply_reset();
        s1 = 1'b0;
        s2 = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick(!s2, 16'(16'h0300 + t), 1'b0, '0, '0, 1'b1);
            s2 = s1;
            s1 = o_stall;
        end
        chk("lag_err", 64'(o_err), 64'd0);
        chk("lag_stall", 64'(o_stall), 64'd1);
        repeat (10) idle(1'b0);

        // Stall threshold edge: 6 entries draining with no new traffic
        apply_reset();
        for (int t = 0; t < 6; t++) tick(1'b1, 16'(16'h0400 + t), 1'b0, '0, '0, 1'b1);
        idle(1'b0);
        chk("th_stall_a", 64'(o_stall), 64'd1);
        idle(1'b0);
        chk("th_stall_b", 64'(o_stall), 64'd1);
        idle(1'b0);
        chk("th_stall_c", 64'(o_stall), 64'd0);
        repeat (8) idle(1'b0);

        // Overflow: 9 pushes without pops, ninth dropped, error sticky
        apply_reset();
        for (int t = 0; t < 9; t++) tick(1'b1, 16'(16'h0500 + t), 1'b0, '0, '0, 1'b1);
        chk("ovf_err_pre", 64'(o_err), 64'd0);
        idle(1'b1);
        chk("ovf_err_set", 64'(o_err), 64'd1);
        repeat (14) idle(1'b0);
        chk("ovf_err_hold", 64'(o_err), 64'd1);

        // Reset with 3 entries queued and 2 reads in flight
        apply_reset();
        for (int t = 0; t < 5; t++) tick(1'b1, 16'(16'h0600 + t), 1'b0, '0, '0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        chk("mid_mrd1", 64'(o_mrd), 64'd1);
        idle(1'b1);
        chk("mid_mrd2", 64'(o_mrd), 64'd1);
        apply_reset();
        for (int t = 0; t < 6; t++) begin
            idle(1'b0);
            chk("post_rst_valid", 64'(o_valid), 64'd0);
        end

        // Random traffic, fetch honouring stall
        apply_reset();
        for (int t = 0; t < 1500; t++) begin
            tick(!o_stall && ($urandom_range(0, 99) < 70), 16'($urandom),
                 $urandom_range(0, 99) < 35, 16'($urandom), $urandom,
                 $urandom_range(0, 99) < 20);
        end
        repeat (10) idle(1'b0);

        // Random traffic, fetch ignoring stall so overflow can occur
        apply_reset();
        for (int t = 0; t < 500; t++) begin
            tick($urandom_range(0, 99) < 80, 16'($urandom),
                 $urandom_range(0, 99) < 30, 16'($urandom), $urandom,
                 $urandom_range(0, 99) < 30);
        end
        repeat (10) idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wu_mem_arb.md
WU_MEM_ARB -- requirements
Module: wu_mem_arb

Interface
REQ-001 SHALL have parameters: ADDR_W, default `MGR_WU_ADDRESS_RANGE` width, WU memory address width; DATA_W, default 32, WU word width; SKID_DEPTH, default 8, fetch read skid entries; WR_BURST, default 4, max consecutive write grants while reads wait; RD_LAT, default 2, memory read latency in cycles.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, all flops on posedge
- reset_poweron_n  in  1  asynchronous, active-low reset
- wuf__wuma__read  in  1  fetch read pulse, one per cycle max
- wuf__wuma__addr  in  ADDR_W  fetch read address
- wuma__wuf__stall  out  1  registered stall to fetch
- sys__wuma__wr_valid  in  1  system load write request
- sys__wuma__wr_addr  in  ADDR_W  write address
- sys__wuma__wr_data  in  DATA_W  write data
- wuma__sys__wr_ready  out  1  write accepted this cycle
- wud__wuma__stall  in  1  decoder cannot take read data
- wuma__wum__read  out  1  memory read strobe
- wuma__wum__write  out  1  memory write strobe
- wuma__wum__addr  out  ADDR_W  memory address
- wuma__wum__wdata  out  DATA_W  memory write data
- wum__wuma__rdata  in  DATA_W  memory read data, RD_LAT after read
- wuma__wud__rdata_valid  out  1  read data valid to decoder
- wuma__wud__rdata  out  DATA_W  read data to decoder
- wuma__err  out  1  sticky skid overflow flag

Function
REQ-003 SHALL push {addr} into an in-order skid FIFO on every cycle wuf__wuma__read=1; the FIFO is never bypassed.
REQ-004 SHALL support simultaneous push and pop in one cycle; occupancy then unchanged.
REQ-005 SHALL drop a push when the FIFO is full and set wuma__err=1, held until reset.
REQ-006 SHALL register wuma__wuf__stall=1 when next-cycle occupancy >= SKID_DEPTH-3, or wud__wuma__stall=1, or a write was granted this cycle; this absorbs the two reads fetch issues after stall.
REQ-007 SHALL grant at most one memory operation per cycle.
REQ-008 SHALL use this arbitration each cycle:
- write eligible: sys__wuma__wr_valid=1
- read eligible: FIFO non-empty and wud__wuma__stall=0
- both eligible and wr_cnt<WR_BURST: grant write
- both eligible and wr_cnt==WR_BURST: grant read
- only one eligible: grant it
REQ-009 SHALL keep wr_cnt (width clog2(WR_BURST+1)) as follows: increment on a write grant while a read is eligible; clear on a read grant or when no read is eligible; saturate at WR_BURST.
REQ-010 SHALL drive wuma__sys__wr_ready combinationally equal to write grant; a write is accepted only on wr_valid&&wr_ready.
REQ-011 SHALL register memory outputs one cycle after grant: read/write strobes mutually exclusive; addr and wdata from the granted source; wdata and addr hold their last value when idle.
REQ-012 SHALL shift each issued read through a RD_LAT-deep valid pipeline; assert wuma__wud__rdata_valid exactly RD_LAT cycles after wuma__wum__read, with wuma__wud__rdata = wum__wuma__rdata that cycle.
REQ-013 SHALL return read data in issue order; there is no address hazard check (system loads complete before fetch enable).
REQ-014 SHALL not block reads already issued to memory when wud__wuma__stall rises; it blocks only new read grants.

Reset
REQ-015 SHALL, on reset_poweron_n=0 regardless of clock, clear: FIFO pointers/occupancy, wr_cnt, the valid pipeline, all strobes, wuma__wuf__stall, wuma__err, and addr/wdata/rdata outputs to 0.
REQ-016 SHALL discard in-flight reads on reset mid-operation; no rdata_valid follows reset release until a new read is issued.

Verification
REQ-017 Single fetch read addr 0x10, no writes -> wum__read at cycle+2 with addr 0x10 (push, grant, register); rdata_valid RD_LAT=2 cycles later.
REQ-018 Fetch reads every cycle with continuous writes -> grant pattern of 4 writes then 1 read, repeating; stall held high throughout.
REQ-019 wud__wuma__stall=1 while fetch streams reads -> stall rises once occupancy reaches 5; at most 2 further pushes; occupancy ≤7; wuma__err stays 0.
REQ-020 Force 9 pushes with no pops (fetch ignores stall) -> 9th push dropped, wuma__err=1 until reset.
REQ-021 Assert reset with 3 FIFO entries and 2 reads in flight -> all outputs 0 immediately; no rdata_valid after release.
REQ-022 Write valid with empty FIFO -> wr_ready=1 same cycle; wum__write=1 next cycle with matching addr/data.
